uart_transceiver: RTL and testbench
===================================

# uart_transceiver

Parametrised full-duplex UART: a transmitter with a valid/ready input handshake and a receiver with a synchroniser, centre sampling, and parity/framing checks. It supersedes the fixed 8-bit, even-parity, 8-clocks-per-bit UART. It adds configurable width, parity mode, stop-bit count, oversampling and synchroniser depth, plus an internal loopback mode for self-test. It sits between the system bus logic and the serial pins.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 8: clk cycles per serial bit, even, at least 4.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 3: rx synchroniser flops, at least 2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- tx_valid  in  1  transmit request.
- tx_data  in  DATA_WIDTH  word to send; sampled only at acceptance.
- tx_ready  out  1  transmitter can accept a word.
- serial_out  out  1  tx line; idles at 1.
- serial_in  in  1  rx line; asynchronous.
- loopback  in  1  when 1, the receiver input is serial_out instead of serial_in.
- rx_data  out  DATA_WIDTH  last received word; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse per completed frame.
- parity_error  out  1  qualified by rx_valid.
- framing_error  out  1  qualified by rx_valid.

## Operation
- Symbols: C = CLKS_PER_BIT, S = SYNC_STAGES, P = (PARITY != 0).
- Frame length in bits: F = 1 + DATA_WIDTH + P + STOP_BITS.
- Frame order: start(0), data LSB first, parity (if P), then STOP_BITS ones.
- Parity bit:
  - Even mode: XOR of the data bits.
  - Odd mode: inverse of that XOR.
- All outputs are registered.
- Reset values, effective the cycle after a reset edge:
  - serial_out = 1, tx_ready = 1.
  - rx_valid = 0, rx_data = 0, parity_error = 0, framing_error = 0.
  - Synchroniser flops = 1.
  - Both FSMs at IDLE.
- Reset mid-frame aborts both directions immediately. No partial rx_valid is produced.
- tx FSM states: IDLE, START, DATA, PARITY, STOP.
  - Acceptance = tx_valid & tx_ready at a clk edge. tx_data is latched; later changes to it are ignored.
  - Each state lasts C cycles; DATA lasts C per bit; STOP lasts C·STOP_BITS.
  - PARITY is skipped when P = 0.
  - tx_ready is low from the cycle after acceptance through the frame.
  - tx_ready is high again in the final cycle of the last stop bit. Acceptance there starts the next frame with no idle gap.
  - tx_valid while tx_ready = 0 is ignored.
- rx FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a synchroniser output of 0 starts the bit counter.
  - At C/2 cycles the start bit is re-sampled. If it reads 1 (glitch), return to IDLE with no rx_valid.
  - Further samples are taken every C cycles at bit centres: data, parity, each stop bit.
  - parity_error = received parity != computed parity; always 0 when P = 0.
  - framing_error = any stop sample reads 0.
  - After the last stop sample, rx_valid pulses with rx_data and both flags. Errored frames are still delivered.
  - Next state after the pulse:
    - No framing error: IDLE, hunting the next start edge immediately.
    - Framing error: WAIT_HIGH. The FSM stays there until the synchroniser output is 1, so a held-low break yields exactly one errored frame.
- Receiver has no backpressure. rx_data is overwritten by the next frame.
- Changing loopback mid-frame may corrupt the current rx frame but must not lock up either FSM. The receiver recovers within one frame time after the line is idle.

## Timing
- Serial_out goes 0 at cycle T+1 after acceptance at edge T.
- Serial_out holds bit k (k = 0 for start) for cycles T+1+k·C .. T+(k+1)·C.
- tx_ready = 1 at cycle T+F·C.
- Let t be the first cycle in which the rx input is 0. Detection occurs at td = t+S.
- Start check at td+C/2; bit k is sampled at td+C/2+k·C.
- rx_valid is high at cycle td+C/2+(F−1)·C+1.
- Loopback, defaults (F = 11): acceptance at T gives rx_valid at T+89, with rx_data equal to the sent word.
- Minimum frame spacing: F·C cycles per word in both directions.

## Test plan
- Loopback, defaults, send 8'hA5:
  - serial_out = 0 for cycles T+1..T+8; bit 0 = 1 for cycles T+9..T+16.
  - rx_valid at T+89, rx_data = 8'hA5, both errors 0.
- Back-to-back, tx_valid held high, words 8'h00 then 8'hFF:
  - Second start bit begins at T+89 with no idle cycle.
  - Two rx_valid pulses, 88 cycles apart, with the correct data.
- Parameter corners, each a loopback run of 9'h155:
  - DATA_WIDTH = 9, PARITY = 2, STOP_BITS = 2, C = 16: F = 13, data received, no errors.
  - PARITY = 0 with the same settings: F = 12.
- External serial_in, defaults:
  - Frame with a flipped parity bit -> rx_valid with parity_error = 1.
  - Frame with stop bit 0 -> framing_error = 1.
  - Line then held low for 500 cycles -> no further rx_valid until the line returns high.
- Glitch rejection: a 2-cycle low pulse on serial_in -> no rx_valid, FSM back in IDLE, next valid frame received correctly.
- Reset mid-frame: reset during data bit 3 of a transmit -> next cycle serial_out = 1, tx_ready = 1, no rx_valid; a subsequent send of 8'h3C completes correctly.

Source files
------------

// File: rtl/uart_transceiver.sv
// Parametrised full-duplex UART: valid/ready transmitter, synchronised centre-sampling
// receiver with parity/framing checks, and an internal loopback path for self-test.
module uart_transceiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  serial_out,
    input  logic                  serial_in,
    input  logic                  loopback,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic [2:0]            tx_state_dbg,
    output logic [2:0]            rx_state_dbg
);
    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit ODD_PARITY = (PARITY == 2);
    localparam int STOP_CLKS  = CLKS_PER_BIT * STOP_BITS;
    localparam int CW         = $clog2(STOP_CLKS + 1);
    localparam int BW         = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] STOP_READY = CW'(STOP_CLKS - 2);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOPS_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Handshake: a word transfers on every clk edge where tx_valid and tx_ready are both
    // high; tx_data is captured only then. tx_valid while tx_ready is low has no effect.
    // tx_ready rises in the last cycle of the final stop bit so a waiting word follows
    // the previous frame with no idle gap.
    tx_state_t             tx_state;
    logic [CW-1:0]         tx_cnt;
    logic [BW-1:0]         tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_state   <= TX_START;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= tx_data;
            tx_par     <= (^tx_data) ^ ODD_PARITY;
            serial_out <= 1'b0;
            tx_ready   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: tx_cnt <= '0;
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state   <= TX_DATA;
                        tx_cnt     <= '0;
                        serial_out <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == DATA_LAST) begin
                            tx_bit <= '0;
                            if (HAS_PARITY) begin
                                tx_state   <= TX_PARITY;
                                serial_out <= tx_par;
                            end else begin
                                tx_state   <= TX_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            tx_bit     <= tx_bit + 1'b1;
                            serial_out <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state   <= TX_STOP;
                        tx_cnt     <= '0;
                        serial_out <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    // All stop bits are one continuous high period.
                    if (tx_cnt == STOP_LAST) begin
                        tx_state <= TX_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == STOP_READY) tx_ready <= 1'b1;
                    end
                end
                default: begin
                    tx_state   <= TX_IDLE;
                    serial_out <= 1'b1;
                    tx_ready   <= 1'b1;
                end
            endcase
        end
    end

    // Loopback is selected ahead of the synchroniser so both paths see identical timing.
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_line;

    always_ff @(posedge clk) begin
        if (reset) rx_sync <= '1;
        else       rx_sync <= {rx_sync[SYNC_STAGES-2:0], loopback ? serial_out : serial_in};
    end

    assign rx_line = rx_sync[SYNC_STAGES-1];

    rx_state_t             rx_state;
    logic [CW-1:0]         rx_cnt;
    logic [BW-1:0]         rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par;
    logic                  rx_stop_err;
    logic                  rx_frame_err;

    assign rx_frame_err = rx_stop_err | ~rx_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_stop_err   <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_line) rx_state <= RX_START;
                end
                RX_START: begin
                    // Half-bit re-check rejects glitches and aligns later samples to bit centres.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt      <= '0;
                        rx_bit      <= '0;
                        rx_stop_err <= 1'b0;
                        rx_state    <= rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_line, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_bit   <= '0;
                            rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_line;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_bit == STOPS_LAST) begin
                            rx_valid      <= 1'b1;
                            rx_data       <= rx_shift;
                            parity_error  <= HAS_PARITY && (rx_par != ((^rx_shift) ^ ODD_PARITY));
                            framing_error <= rx_frame_err;
                            rx_state      <= rx_frame_err ? RX_WAIT_HIGH : RX_IDLE;
                        end else begin
                            rx_bit      <= rx_bit + 1'b1;
                            rx_stop_err <= rx_frame_err;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low line (break) must not be decoded as back-to-back frames.
                    rx_cnt <= '0;
                    if (rx_line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: default-parameter instance on loopback and
// external pins, plus two loopback parameter-corner instances.
module tb_uart_transceiver;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic       tx_valid, tx_ready, serial_out, serial_in, loopback;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, parity_error, framing_error;
    logic [2:0] tx_state_dbg, rx_state_dbg;

    uart_transceiver u_dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .serial_out(serial_out), .serial_in(serial_in), .loopback(loopback),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
        .framing_error(framing_error), .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
    );

    // Corner 1: 9 data bits, odd parity, 2 stop bits, 16 clocks per bit (F = 13)
    logic       c1_tx_valid, c1_tx_ready, c1_serial_out, c1_rx_valid, c1_pe, c1_fe;
    logic [8:0] c1_tx_data, c1_rx_data;
    logic [2:0] c1_tx_st, c1_rx_st;

    uart_transceiver #(.DATA_WIDTH(9), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(2)) u_c1 (
        .clk(clk), .reset(reset), .tx_valid(c1_tx_valid), .tx_data(c1_tx_data),
        .tx_ready(c1_tx_ready), .serial_out(c1_serial_out), .serial_in(1'b1), .loopback(1'b1),
        .rx_data(c1_rx_data), .rx_valid(c1_rx_valid), .parity_error(c1_pe),
        .framing_error(c1_fe), .tx_state_dbg(c1_tx_st), .rx_state_dbg(c1_rx_st)
    );

    // Corner 2: as corner 1 but without parity (F = 12)
    logic       c2_tx_valid, c2_tx_ready, c2_serial_out, c2_rx_valid, c2_pe, c2_fe;
    logic [8:0] c2_tx_data, c2_rx_data;
    logic [2:0] c2_tx_st, c2_rx_st;

    uart_transceiver #(.DATA_WIDTH(9), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(2)) u_c2 (
        .clk(clk), .reset(reset), .tx_valid(c2_tx_valid), .tx_data(c2_tx_data),
        .tx_ready(c2_tx_ready), .serial_out(c2_serial_out), .serial_in(1'b1), .loopback(1'b1),
        .rx_data(c2_rx_data), .rx_valid(c2_rx_valid), .parity_error(c2_pe),
        .framing_error(c2_fe), .tx_state_dbg(c2_tx_st), .rx_state_dbg(c2_rx_st)
    );

    // Scoreboard
    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [7:0] exp_q[$];
    int         rx_cyc_q[$];
    logic [7:0] rx_dat_q[$];
    logic [1:0] rx_err_q[$];
    int         rx_pulses = 0;

    // Recorded cycle number is the spec's cycle index (edge count + 1).
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cyc_q.push_back(cyc + 1);
            rx_dat_q.push_back(rx_data);
            rx_err_q.push_back({parity_error, framing_error});
            rx_pulses <= rx_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc + 1);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc + 1 < target) @(negedge clk);
    endtask

    task automatic drive_bits(input logic b, input int n);
        serial_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop,
                               output int t_start);
        t_start = cyc + 1;
        drive_bits(1'b0, 8);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 8);
        drive_bits(par, 8);
        drive_bits(stop, 8);
    endtask

    // Returns the edge number at which the word was accepted.
    task automatic send_word(input logic [7:0] w, output int t_acc);
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        t_acc    = cyc;
        tx_valid = 1'b0;
        tx_data  = ~w;
    endtask

    task automatic expect_rx(input string tag, input int exp_cyc, input logic [1:0] exp_err);
        int         n = 0;
        logic [7:0] e;
        while (rx_dat_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        if (rx_dat_q.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_cycle"}, rx_cyc_q.pop_front(), exp_cyc);
        check({tag, "_data"}, rx_dat_q.pop_front(), e);
        check({tag, "_errors"}, rx_err_q.pop_front(), exp_err);
    endtask

    int          t, ts, p0;
    logic [10:0] frame;
    int          c1_rdy, c2_rdy, c1_rx, c2_rx;
    logic [8:0]  c1_dat, c2_dat;
    logic [1:0]  c1_err, c2_err;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tx_valid = 1'b0; tx_data = '0; serial_in = 1'b1; loopback = 1'b1;
        c1_tx_valid = 1'b0; c1_tx_data = '0; c2_tx_valid = 1'b0; c2_tx_data = '0;
        repeat (3) @(negedge clk);

        check("rst_serial_out", serial_out, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_errors", {parity_error, framing_error}, 0);
        check("rst_states", {tx_state_dbg, rx_state_dbg}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback A5: full frame shape on serial_out and tx_ready timing.
        exp_q.push_back(8'hA5);
        send_word(8'hA5, t);
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
        for (int c = 1; c <= 88; c++) begin
            wait_until(t + c);
            check("a5_serial_out", serial_out, frame[(c - 1) / 8]);
            check("a5_tx_ready", tx_ready, (c == 88));
        end
        expect_rx("a5_rx", t + 89, 2'b00);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk);
        t = cyc;
        tx_data = 8'hFF; exp_q.push_back(8'hFF);
        wait_until(t + 88);
        check("b2b_stop_bit", serial_out, 1);
        check("b2b_ready_last_stop", tx_ready, 1);
        wait_until(t + 89);
        check("b2b_second_start", serial_out, 0);
        check("b2b_ready_low", tx_ready, 0);
        tx_valid = 1'b0;
        expect_rx("b2b_first", t + 89, 2'b00);
        expect_rx("b2b_second", t + 177, 2'b00);

        // External pin: clean frame, flipped parity, bad stop bit then a break.
        wait_until(t + 200);
        loopback = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b0, 1'b1, ts);
        drive_bits(1'b1, 10);
        expect_rx("ext_clean", ts + 88, 2'b00);

        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1, 1'b1, ts);
        drive_bits(1'b1, 10);
        expect_rx("ext_parity", ts + 88, 2'b10);

        p0 = rx_pulses;
        exp_q.push_back(8'h33);
        drive_frame(8'h33, 1'b0, 1'b0, ts);
        drive_bits(1'b0, 500);
        check("break_wait_high", rx_state_dbg, 5);
        check("break_one_frame", rx_pulses, p0 + 1);
        expect_rx("ext_framing", ts + 88, 2'b01);
        drive_bits(1'b1, 30);
        check("break_release_idle", rx_state_dbg, 0);
        check("break_no_extra", rx_pulses, p0 + 1);

        // Glitch rejection.
        p0 = rx_pulses;
        drive_bits(1'b0, 2);
        drive_bits(1'b1, 20);
        check("glitch_no_valid", rx_pulses, p0);
        check("glitch_idle", rx_state_dbg, 0);
        exp_q.push_back(8'hC3);
        drive_frame(8'hC3, 1'b0, 1'b1, ts);
        drive_bits(1'b1, 10);
        expect_rx("post_glitch", ts + 88, 2'b00);

        // Reset during data bit 3 of a loopback transmit.
        loopback = 1'b1;
        p0 = rx_pulses;
        send_word(8'h96, t);
        wait_until(t + 36);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_serial_out", serial_out, 1);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_states", {tx_state_dbg, rx_state_dbg}, 0);
        check("mid_rst_rx_data", rx_data, 0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_rst_no_rx", rx_pulses, p0);
        exp_q.push_back(8'h3C);
        send_word(8'h3C, t);
        expect_rx("post_reset", t + 89, 2'b00);

        // Parameter corners, loopback of 9'h155 on both.
        c1_rdy = -1; c2_rdy = -1; c1_rx = -1; c2_rx = -1;
        c1_dat = '0; c2_dat = '0; c1_err = 2'b11; c2_err = 2'b11;
        c1_tx_valid = 1'b1; c2_tx_valid = 1'b1;
        c1_tx_data = 9'h155; c2_tx_data = 9'h155;
        @(negedge clk);
        t = cyc;
        c1_tx_valid = 1'b0; c2_tx_valid = 1'b0;
        c1_tx_data = '0; c2_tx_data = '0;
        for (int c = 1; c <= 260; c++) begin
            wait_until(t + c);
            if (c1_tx_ready && c1_rdy < 0) c1_rdy = c;
            if (c2_tx_ready && c2_rdy < 0) c2_rdy = c;
            if (c1_rx_valid) begin c1_rx = c; c1_dat = c1_rx_data; c1_err = {c1_pe, c1_fe}; end
            if (c2_rx_valid) begin c2_rx = c; c2_dat = c2_rx_data; c2_err = {c2_pe, c2_fe}; end
            if (c == 152) check("c1_data_bit8", c1_serial_out, 1);
            if (c == 168) check("c1_parity_bit", c1_serial_out, 0);
            if (c == 168) check("c2_first_stop", c2_serial_out, 1);
            if (c == 200) check("c1_second_stop", c1_serial_out, 1);
        end
        check("c1_tx_ready_cycle", c1_rdy, 208);
        check("c1_rx_cycle", c1_rx, 205);
        check("c1_rx_data", c1_dat, 9'h155);
        check("c1_rx_errors", c1_err, 2'b00);
        check("c2_tx_ready_cycle", c2_rdy, 192);
        check("c2_rx_cycle", c2_rx, 189);
        check("c2_rx_data", c2_dat, 9'h155);
        check("c2_rx_errors", c2_err, 2'b00);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
